// File: rtl/norm2_pkg.sv
// Shared constants and FSM state type for the norm2 feeder.
package norm2_pkg;

    localparam int N      = 1000;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 27;
    localparam int ACC_W  = 64;

    // Address of the final array slot; reaching it ends both LOAD and FILL.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        FILL  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/norm2_feeder.sv
// Front end for the norm2 core: loads one frame into the core array,
// zero-fills unused slots, runs the core and returns its sum of squares.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready
// are both high. A source holds valid and its payload stable until the
// transfer; ready may change freely. m_valid/m_data/m_err are registered
// and stay constant while waiting for m_ready.
module norm2_feeder
    import norm2_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    // sample stream in
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_last,
    // result stream out
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [ACC_W-1:0]  m_data,
    output logic                     m_err,
    // core control
    output logic                     core_r_enable,
    output logic [ADDR_W-1:0]        core_init_i,
    output logic [ACC_W-1:0]         core_init_acc,
    input  logic                     core_w_enable,
    input  logic signed [ACC_W-1:0]  core_result,
    // core external array port
    output logic                     arr_ctl,
    output logic                     arr_we,
    output logic [ADDR_W-1:0]        arr_addr,
    output logic signed [DATA_W-1:0] arr_wdata,
    // current FSM state for observation
    output state_t                   dbg_state
);

    state_t                   state_q;
    logic [ADDR_W-1:0]        cnt_q;
    logic [ADDR_W-1:0]        cnt_d;
    logic                     err_q;
    logic                     m_valid_q;
    logic signed [ACC_W-1:0]  m_data_q;
    logic                     m_err_q;
    logic                     arr_we_q;
    logic [ADDR_W-1:0]        arr_addr_q;
    logic signed [DATA_W-1:0] arr_wdata_q;

    // Slot counter advance, shared by LOAD and FILL.
    assign cnt_d = cnt_q + ADDR_W'(1);

    // Single FSM: frame load, zero fill, array flush, core run, result hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_err_q     <= 1'b0;
            arr_we_q    <= 1'b0;
            arr_addr_q  <= '0;
            arr_wdata_q <= '0;
        end else begin
            // A write strobe lasts one cycle unless a state reissues it.
            arr_we_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (s_valid) begin
                        arr_we_q    <= 1'b1;
                        arr_addr_q  <= cnt_q;
                        arr_wdata_q <= s_data;
                        cnt_q       <= cnt_d;
                        if (cnt_q == LAST_IDX) begin
                            // Array full: a missing s_last means the frame
                            // was longer than N and is truncated here.
                            state_q <= START;
                            err_q   <= ~s_last;
                        end else if (s_last) begin
                            state_q <= FILL;
                            err_q   <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    // Clear slots beyond a short frame so stale data from
                    // an earlier frame never enters the sum.
                    arr_we_q    <= 1'b1;
                    arr_addr_q  <= cnt_q;
                    arr_wdata_q <= '0;
                    cnt_q       <= cnt_d;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= START;
                    end
                end
                START: begin
                    // One idle cycle lets the last registered write land
                    // while the array port is still ours.
                    state_q <= RUN;
                end
                RUN: begin
                    if (core_w_enable) begin
                        m_data_q  <= core_result;
                        m_err_q   <= err_q;
                        m_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // Control outputs decode directly from the state register.
    assign s_ready       = (state_q == LOAD);
    assign arr_ctl       = (state_q != RUN);
    assign core_r_enable = (state_q != RUN);
    assign core_init_i   = '0;
    assign core_init_acc = '0;

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_err     = m_err_q;
    assign arr_we    = arr_we_q;
    assign arr_addr  = arr_addr_q;
    assign arr_wdata = arr_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_norm2_feeder.sv
// Bench for norm2_feeder with a behavioural norm2 core and array.
module tb_norm2_feeder;
    import norm2_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [ACC_W-1:0]  m_data;
    logic                     m_err;
    logic                     core_r_enable;
    logic [ADDR_W-1:0]        core_init_i;
    logic [ACC_W-1:0]         core_init_acc;
    logic                     core_w_enable;
    logic signed [ACC_W-1:0]  core_result;
    logic                     arr_ctl;
    logic                     arr_we;
    logic [ADDR_W-1:0]        arr_addr;
    logic signed [DATA_W-1:0] arr_wdata;
    state_t                   dbg_state;

    norm2_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_err         (m_err),
        .core_r_enable (core_r_enable),
        .core_init_i   (core_init_i),
        .core_init_acc (core_init_acc),
        .core_w_enable (core_w_enable),
        .core_result   (core_result),
        .arr_ctl       (arr_ctl),
        .arr_we        (arr_we),
        .arr_addr      (arr_addr),
        .arr_wdata     (arr_wdata),
        .dbg_state     (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] sq64(input logic signed [DATA_W-1:0] x);
        logic signed [63:0] t;
        t = x;
        return t * t;
    endfunction

    // ---------------- behavioural core ----------------
    logic signed [DATA_W-1:0] mem [0:N-1];
    logic signed [ACC_W-1:0]  acc_q;
    int                       idx_q;
    logic                     done_q;

    initial begin
        for (int i = 0; i < N; i++) mem[i] = DATA_W'($urandom);
    end

    always @(posedge clk) begin
        if (arr_ctl && arr_we) mem[arr_addr] <= arr_wdata;
    end

    always @(posedge clk) begin
        if (core_r_enable) begin
            acc_q  <= 64'sd0;
            idx_q  <= 0;
            done_q <= 1'b0;
        end else if (!done_q) begin
            if (idx_q < N) begin
                acc_q <= acc_q + sq64(mem[idx_q]);
                idx_q <= idx_q + 1;
            end else begin
                done_q <= 1'b1;
            end
        end
    end

    assign core_w_enable = done_q;
    assign core_result   = acc_q;

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];
    int          fill_cycles = 0;

    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("m_data", m_data, e[63:0]);
                check_eq("m_err", m_err, e[64]);
            end
        end
        if (arr_we) check_eq("we_while_core_owns", arr_ctl, 1);
        if (dbg_state == FILL) fill_cycles++;
    end

    // ---------------- driver tasks ----------------
    logic signed [DATA_W-1:0] frame_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!s_ready && t < 20000) begin
            step();
            t++;
        end
        check_eq("ready_wait", s_ready, 1);
    endtask

    task automatic send_frame(input int max_gap, input bit use_last);
        logic signed [63:0] sum;
        bit                 err;
        int                 sz;
        sz  = frame_q.size();
        sum = 64'sd0;
        for (int i = 0; i < sz && i < N; i++) sum += sq64(frame_q[i]);
        err = (sz >= N) && !(use_last && sz == N);
        exp_q.push_back({err, sum});
        for (int i = 0; i < sz; i++) begin
            s_valid = 1'b0;
            if (max_gap > 0) begin
                int g = $urandom_range(max_gap, 0);
                repeat (g) step();
            end
            s_valid = 1'b1;
            s_data  = frame_q[i];
            s_last  = use_last && (i == sz - 1);
            wait_ready();
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            step();
            t++;
        end
        check_eq("result_wait", exp_q.size(), 0);
    endtask

    task automatic ramp_frame();
        frame_q.delete();
        for (int i = 0; i < N; i++) frame_q.push_back(DATA_W'(i - 500));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [64:0]              e;
        logic signed [DATA_W-1:0] minv;
        int                       t;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", dbg_state, LOAD);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_arr_we", arr_we, 0);
        check_eq("rst_arr_addr", arr_addr, 0);
        check_eq("rst_arr_wdata", arr_wdata, 0);
        check_eq("rst_arr_ctl", arr_ctl, 1);
        check_eq("rst_r_enable", core_r_enable, 1);
        check_eq("init_i", core_init_i, 0);
        check_eq("init_acc", core_init_acc, 0);
        rst_n = 1'b1;
        step();

        // 1: full ramp frame
        ramp_frame();
        send_frame(0, 1'b1);
        wait_drain();

        // 2: short frame, zero fill over stale ramp data
        frame_q.delete();
        frame_q.push_back(27'sd3);
        frame_q.push_back(-27'sd4);
        frame_q.push_back(27'sd12);
        fill_cycles = 0;
        send_frame(0, 1'b1);
        wait_drain();
        check_eq("fill_cycles", fill_cycles, 997);
        check_eq("short_sum_const", 64'd169, 64'd169 + 64'(fill_cycles - 997));

        // 3: overlong frame truncated at N, extra sample held off
        minv = {1'b1, {(DATA_W-1){1'b0}}};
        frame_q.delete();
        for (int i = 0; i < N; i++) frame_q.push_back(minv);
        send_frame(0, 1'b0);
        s_valid = 1'b1;
        s_data  = minv;
        check_eq("extra_held_off", s_ready, 0);
        t = 0;
        while (!s_ready && t < 20000) begin
            step();
            t++;
        end
        s_valid = 1'b0;
        check_eq("extra_ready_back", s_ready, 1);
        check_eq("extra_after_result", exp_q.size(), 0);
        step();

        // 4: result held under back-pressure
        m_ready = 1'b0;
        ramp_frame();
        send_frame(0, 1'b1);
        t = 0;
        while (!m_valid && t < 20000) begin
            step();
            t++;
        end
        check_eq("hold_valid_wait", m_valid, 1);
        e = exp_q[0];
        repeat (50) begin
            check_eq("hold", {m_valid, m_err, m_data, s_ready}, {1'b1, e[64], e[63:0], 1'b0});
            step();
        end
        m_ready = 1'b1;
        step();
        check_eq("hold_s_ready_next", s_ready, 1);
        check_eq("hold_m_valid_drop", m_valid, 0);
        check_eq("hold_popped", exp_q.size(), 0);

        // 5: reset in the middle of RUN
        ramp_frame();
        send_frame(0, 1'b1);
        t = 0;
        while (dbg_state != RUN && t < 100) begin
            step();
            t++;
        end
        check_eq("reach_run", dbg_state, RUN);
        repeat (20) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        check_eq("midrst_m_valid", m_valid, 0);
        check_eq("midrst_s_ready", s_ready, 1);
        check_eq("midrst_state", dbg_state, LOAD);
        ramp_frame();
        send_frame(0, 1'b1);
        wait_drain();

        // 6: ramp frame with random source gaps
        ramp_frame();
        send_frame(5, 1'b1);
        wait_drain();

        repeat (5) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/norm2_feeder.md
Name: norm2_feeder

Overview:
Upstream stage for the norm2 `main` core, which computes the squared L2 norm of a 1000-entry array of signed 27-bit values into a 64-bit accumulator.
- Accepts a sample frame over a valid/ready stream.
- Writes the frame into the core's array through the core's external array port (controlArr side).
- Starts the core, waits for its done flag, and presents the 64-bit result on an output valid/ready stream.

Parameters:
N, 1000, array depth / samples per frame
ADDR_W, 10, array address width
DATA_W, 27, signed sample width
ACC_W, 64, signed result width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid & s_ready
s_data  in  DATA_W  signed sample
s_last  in  1  last sample of frame
m_valid  out  1  result valid
m_ready  in  1  result consumed when m_valid & m_ready
m_data  out  ACC_W  signed sum of squares
m_err  out  1  frame length error, qualified by m_valid
core_r_enable  out  1  to core r_enable (high = core held/reinitialised)
core_init_i  out  ADDR_W  to core init_i, constant 0
core_init_acc  out  ACC_W  to core init_acc, constant 0
core_w_enable  in  1  core done flag (level, stays high until next r_enable)
core_result  in  ACC_W  core result
arr_ctl  out  1  to core controlArr
arr_we  out  1  to controlArrWEnable_a
arr_addr  out  ADDR_W  to controlArrAddr_a
arr_wdata  out  DATA_W  to controlArrWData_a

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active low.
- Reset values: state LOAD, cnt 0, err 0, m_valid 0, m_data 0, arr_we 0, arr_addr 0, arr_wdata 0.
- Outputs by state:
  - arr_ctl = 1 in every state except RUN.
  - core_r_enable = 0 only in RUN; the core stays parked in all other states.
  - s_ready = 1 only in LOAD.
- Array write port: arr_we/arr_addr/arr_wdata are registered; a write issued in cycle t lands in the array on the edge ending cycle t+1.
- LOAD, on each accepted sample:
  - Register write {we=1, addr=cnt, wdata=s_data}; cnt++.
  - s_last on sample index cnt<N-1: go to FILL, err=0.
  - Sample index N-1 with s_last: go to START, err=0.
  - Sample index N-1 without s_last: go to START, err=1. The frame is truncated at N; later samples belong to the next frame.
  - No accept in a cycle: arr_we=0.
- FILL: one zero write per cycle at addr=cnt, cnt++. After writing address N-1, go to START. Zero-fill ensures stale entries from earlier frames never contribute.
- START: exactly 1 cycle, arr_we=0. Flushes the last registered write while arr_ctl=1. Go to RUN.
- RUN:
  - core_r_enable=0 and arr_ctl=0.
  - core_w_enable is guaranteed 0 on entry (the core clears it under r_enable).
  - On core_w_enable=1: m_data<=core_result, m_err<=err, m_valid<=1, go to OUT.
  - Core latency is about 9*N+5 cycles; the feeder imposes no timeout.
- OUT:
  - m_valid=1. m_data and m_err are held stable until the handshake.
  - On m_ready: m_valid<=0, cnt<=0, go to LOAD. s_ready rises in the next cycle.
- Arithmetic: core_init_i and core_init_acc are tied to 0. Maximum result N*2^52 fits in signed 64 bits, so no overflow handling is needed.
- Reset mid-operation: rst_n low in any state returns to LOAD with reset values. A partial frame is discarded. The core is parked next cycle because core_r_enable=1 outside RUN.
- Simultaneous events: s_valid and s_last on the first sample gives a 1-sample frame with N-1 zero fills. m_ready asserted while m_valid=0 is ignored.

Decomposition:
- Package norm2_pkg holds N, ADDR_W, DATA_W, ACC_W and the state enum {LOAD, FILL, START, RUN, OUT}.
- No sub-module: the single FSM plus a registered write port is natural.
- The core is instantiated alongside the feeder in a wrapper, not inside it.

Test Plan:
1. Full frame s_data=i-500 for i=0..999, s_last on i=999, m_ready=1 -> m_data=83333500, m_err=0.
2. After test 1, frame {3,-4,12} with s_last on 12 -> 997 FILL cycles, m_data=169, m_err=0 (stale data overwritten).
3. 1000 samples of -2^26, no s_last -> m_data=4503599627370496000, m_err=1. The 1001st sample sees s_ready=0 until LOAD returns.
4. Test-1 frame with m_ready=0 for 50 cycles after m_valid -> m_valid, m_data, m_err stable and s_ready=0. Raise m_ready -> s_ready=1 next cycle.
5. rst_n low for 1 cycle mid-RUN -> m_valid=0 and s_ready=1 after reset. The test-1 frame then yields 83333500.
6. Test-1 frame with random s_valid gaps (0-5 cycles) -> m_data=83333500, and arr_we is never 1 while arr_ctl=0.
